// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit ALU: single-step arithmetic/logic, iterative shift/rotate,
// registered result and flags, start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             is_shift,
    input  logic [1:0]       scode,
    input  logic [2:0]       acode,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, r_q, r_d;
    logic             cin_q, cin_d, is_shift_q, is_shift_d, cw_q, cw_d;
    logic [1:0]       scode_q, scode_d;
    logic [2:0]       acode_q, acode_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             zero_q, zero_d, carry_q, carry_d, done_q, done_d;
    logic [WIDTH:0]   alu_res;

    always_comb begin
        alu_res = '0;
        case (acode_q)
            3'b000: alu_res = {1'b0, a_q} + {1'b0, b_q};
            3'b001: alu_res = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
            3'b010: alu_res = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
            3'b011: alu_res = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(cin_q);
            3'b100: alu_res = {1'b0, a_q & b_q};
            3'b101: alu_res = {1'b0, a_q | b_q};
            3'b110: alu_res = {1'b0, a_q ^ b_q};
            default: alu_res = {1'b0, a_q & ~b_q};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        is_shift_d = is_shift_q;
        scode_d    = scode_q;
        acode_d    = acode_q;
        w_d        = w_q;
        cw_d       = cw_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    cin_d      = carry_in;
                    is_shift_d = is_shift;
                    scode_d    = scode;
                    acode_d    = acode;
                    w_d        = a;
                    // Seeding with the current flag makes a zero-length shift keep carry_out.
                    cw_d       = carry_q;
                    cnt_d      = b[SHW-1:0];
                    state_d    = (is_shift && b[SHW-1:0] != '0) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                case (scode_q)
                    2'b00: begin cw_d = w_q[WIDTH-1]; w_d = {w_q[WIDTH-2:0], 1'b0}; end
                    2'b01: begin cw_d = w_q[0];       w_d = {w_q[WIDTH-1], w_q[WIDTH-1:1]}; end
                    2'b10: begin cw_d = w_q[WIDTH-1]; w_d = {w_q[WIDTH-2:0], w_q[WIDTH-1]}; end
                    default: begin cw_d = w_q[0];     w_d = {w_q[0], w_q[WIDTH-1:1]}; end
                endcase
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) state_d = FIN;
            end
            FIN: begin
                if (is_shift_q) begin
                    r_d     = w_q;
                    carry_d = cw_q;
                end else begin
                    r_d     = alu_res[WIDTH-1:0];
                    carry_d = alu_res[WIDTH];
                end
                zero_d  = (r_d == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            is_shift_q <= 1'b0;
            scode_q    <= '0;
            acode_q    <= '0;
            w_q        <= '0;
            cw_q       <= 1'b0;
            cnt_q      <= '0;
            r_q        <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            is_shift_q <= is_shift_d;
            scode_q    <= scode_d;
            acode_q    <= acode_d;
            w_q        <= w_d;
            cw_q       <= cw_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            done_q     <= done_d;
        end
    end

    assign r         = r_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): model results queued at issue, checked on done.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk, rst_n, start, carry_in, is_shift;
  logic [W-1:0] a, b, r;
  logic [1:0]   scode;
  logic [2:0]   acode;
  logic         zero, carry_out, busy, done;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .is_shift(is_shift), .scode(scode), .acode(acode), .r(r), .zero(zero),
    .carry_out(carry_out), .busy(busy), .done(done)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  logic m_c = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
  endtask

  // Scoreboard consumer: every done must match the oldest issued operation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("r", r, e.r);
        chk("zero", zero, e.z);
        chk("carry", carry_out, e.c);
        chk("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic run(input logic sh, input logic [2:0] code, input logic [W-1:0] a_i,
                     input logic [W-1:0] b_i, input logic cin_i, input bit repulse);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] w;
    logic         c;
    int           n;
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    s = '0; w = '0; c = 1'b0; n = 0;
    if (!sh) begin
      case (code)
        3'd0: s = {1'b0, a_i} + {1'b0, b_i};
        3'd1: s = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
        3'd2: s = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
        3'd3: s = {1'b0, a_i} + {1'b0, ~b_i} + {8'd0, cin_i};
        3'd4: s = {1'b0, a_i & b_i};
        3'd5: s = {1'b0, a_i | b_i};
        3'd6: s = {1'b0, a_i ^ b_i};
        default: s = {1'b0, a_i & ~b_i};
      endcase
      w = s[W-1:0];
      c = s[W];
    end else begin
      n = int'(b_i[2:0]);
      w = a_i;
      c = m_c;
      for (int k = 0; k < n; k++) begin
        case (code[1:0])
          2'd0: begin c = w[7]; w = w << 1; end
          2'd1: begin c = w[0]; w = {w[7], w[7:1]}; end
          2'd2: begin c = w[7]; w = {w[6:0], w[7]}; end
          default: begin c = w[0]; w = {w[0], w[7:1]}; end
        endcase
      end
    end
    m_c   = c;
    e.r   = w;
    e.z   = (w == 0);
    e.c   = c;
    e.acc = cyc + 1;
    e.lat = 2 + n;
    sb.push_back(e);
    is_shift = sh; scode = code[1:0]; acode = code;
    a = a_i; b = b_i; carry_in = cin_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    if (repulse) begin
      @(negedge clk);
      start = 1'b1; a = 8'h00;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    is_shift = 1'b0; scode = '0; acode = '0;
    #12;
    chk("rst_r", r, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 3'd0, 8'h7F, 8'h01, 0, 0);   // ADD
    run(0, 3'd2, 8'h05, 8'h05, 0, 0);   // SUB
    run(0, 3'd3, 8'h00, 8'h00, 0, 0);   // SBC
    run(0, 3'd7, 8'hFF, 8'h0F, 0, 0);   // MASK
    run(0, 3'd4, 8'hF0, 8'h0F, 0, 0);   // AND
    run(0, 3'd1, 8'hFF, 8'h00, 1, 0);   // ADC wrap
    run(1, 3'd0, 8'h81, 8'h01, 0, 0);   // SHL 1
    run(1, 3'd3, 8'h01, 8'h01, 0, 0);   // ROR 1
    run(1, 3'd2, 8'h80, 8'h09, 0, 0);   // ROL, upper b bits ignored
    run(1, 3'd1, 8'h80, 8'h03, 0, 1);   // SAR 3 with ignored re-start
    run(1, 3'd0, 8'h80, 8'h01, 0, 0);   // SHL -> carry 1
    run(1, 3'd3, 8'h5A, 8'h00, 0, 0);   // amount 0 keeps carry
    for (int i = 0; i < 6; i++)
      run(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    run(1, 3'd2, 8'hC3, 8'h07, 0, 0);   // ROL 7

    // Reset during a SAR by 7: abandon with no done.
    @(negedge clk);
    is_shift = 1'b1; scode = 2'd1; a = 8'h80; b = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_r", r, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_carry", carry_out, 0);
    chk("midrst_busy", busy, 0);
    m_c = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", done, 0);
    run(0, 3'd0, 8'h12, 8'h34, 0, 0);   // ADD after reset

    repeat (3) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle 8-bit datapath ALU.
- Provides the same arithmetic, logic and shift operation set at WIDTH bits.
- Adds the MASK (bit-clear) operation, registered flags and a start/busy/done handshake.
- Sits between the register-file read stage and writeback; the controller stalls on busy.
- Shifts and rotates run iteratively, one bit position per clock, to keep the barrel shifter out of the critical path.

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from b.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  operand A (shift/rotate source).
- b  input  WIDTH  operand B; for shifts, amount = b[SHW-1:0] (upper bits ignored).
- carry_in  input  1  carry for ADC/SBC.
- is_shift  input  1  1 = shift/rotate group, 0 = arithmetic/logic group.
- scode  input  2  00 SHL, 01 SAR, 10 ROL, 11 ROR.
- acode  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 MASK.
- r  output  WIDTH  registered result.
- zero  output  1  registered, r == 0.
- carry_out  output  1  registered carry flag.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; r/zero/carry_out valid from this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - r=0, zero=0, carry_out=0, busy=0, done=0.
  - Reset mid-operation abandons the operation; no done pulse is issued.
- States: IDLE, SHIFT, FIN.
- IDLE, start=1:
  - Latch a, b, carry_in, is_shift, scode, acode, and amount = b[SHW-1:0].
  - Set busy=1.
  - ALU op, or shift with amount 0: go to FIN.
  - Shift with amount > 0: go to SHIFT, working reg = a, counter = amount.
- start while busy=1 is ignored; the latched operands are unaffected.
- ALU ops (result computed at WIDTH+1 bits, carry_out = bit WIDTH):
  - ADD: a+b.
  - ADC: a+b+carry_in.
  - SUB: a+~b+1 (carry=1 means no borrow).
  - SBC: a+~b+carry_in.
  - AND, OR, XOR, MASK (a & ~b): carry_out=0.
- SHIFT: each cycle performs one step and decrements the counter; on reaching 0, go to FIN.
  - SHL: carry<=w[WIDTH-1], w<=w<<1.
  - SAR: carry<=w[0], w<={w[WIDTH-1], w[WIDTH-1:1]}.
  - ROL: carry<=w[WIDTH-1], w<={w[WIDTH-2:0], w[WIDTH-1]}.
  - ROR: carry<=w[0], w<={w[0], w[WIDTH-1:1]}.
- Shift amount 0: r=a; carry_out keeps its previous value.
- FIN:
  - Load r, zero=(result==0) and carry_out.
  - done=1, busy=0; return to IDLE.
  - A start in the FIN cycle is not accepted. It is accepted on the following IDLE cycle if still asserted.
- Latency from start-accept edge to done:
  - ALU ops, or amount 0: 2 cycles.
  - Shift with amount n: n+2 cycles.
- Outputs r/zero/carry_out hold their values between done pulses; the internal working register is not visible on r.
- zero and carry_out update only at FIN; they never glitch during SHIFT.

Test Plan:
- Reset, then ADD a=0x7F b=0x01 (WIDTH=8) -> r=0x80, zero=0, carry_out=0; done exactly 2 cycles after accept.
- SUB a=0x05 b=0x05, then SBC a=0x00 b=0x00 carry_in=0 -> r=0x00/zero=1/carry=1, then r=0xFF/zero=0/carry=0.
- MASK a=0xFF b=0x0F -> r=0xF0, carry=0; AND a=0xF0 b=0x0F -> r=0x00, zero=1.
- SHL a=0x81 b=1 -> r=0x02, carry=1, done after 3 cycles; ROR a=0x01 b=1 -> r=0x80, carry=1; ROL a=0x80 b=0x09 (amount 1) -> r=0x01, carry=1.
- SAR a=0x80 b=3 with start re-pulsed during busy (a=0x00) -> second start ignored; r=0xF0, carry=0, done after 5 cycles; shift with b=0 after carry=1 -> r=a, carry stays 1.
- Assert rst_n=0 in the 2nd cycle of SAR by 7 -> outputs 0 immediately, no done; a new ADD after release completes normally.
